// File: rtl/user_uart_pkg.sv
// Shared types and constants for the user-area 8N1 UART transmitter.
package user_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int MIN_DIV    = 4;

endpackage

// File: rtl/user_uart_tx_if.sv
// Byte-push, control and status signals between user logic and the UART transmitter.
interface user_uart_tx_if #(
  parameter int DIV_W = 16,
  parameter int LVL_W = 3
);
  logic             en;
  logic [DIV_W-1:0] clk_div;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             tx;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output en, clk_div, in_data, in_valid,
    input  in_ready, tx, busy, fifo_level
  );

  modport slave (
    input  en, clk_div, in_data, in_valid,
    output in_ready, tx, busy, fifo_level
  );
endinterface

// File: rtl/user_uart_fifo.sv
// Synchronous FIFO; full/empty come from an extra wrap bit on each pointer.
module user_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign level_o   = LVL_W'(wr_ptr_q - rd_ptr_q);
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];
  // A push is judged against the pre-edge occupancy, so a same-cycle pop never frees room for it.
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // Pointer update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  // Storage write
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/user_uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes serialised LSB first at a run-time bit period.
module user_uart_tx
  import user_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  user_uart_tx_if.slave  bus
);
  localparam int CNT_W = $clog2(FRAME_BITS);

  uart_state_e      state_q;
  logic             tx_q;
  logic [7:0]       shift_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] baud_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [7:0]       fifo_rdata_s;
  logic [LVL_W-1:0] fifo_level_s;
  logic             can_start_s;
  logic             bit_end_s;
  logic             pop_s;
  logic [DIV_W-1:0] div_eff_s;

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    if (d < DIV_W'(MIN_DIV)) begin
      return DIV_W'(MIN_DIV);
    end else begin
      return d;
    end
  endfunction

  user_uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (bus.in_valid),
    .wdata_i (bus.in_data),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level_s)
  );

  assign can_start_s = bus.en && !fifo_empty_s;
  assign bit_end_s   = (baud_q == '0);
  assign div_eff_s   = clamp_div(bus.clk_div);

  // Frame starts pop the FIFO head, either from idle or straight out of a stop bit.
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      IDLE:    pop_s = can_start_s;
      STOP:    pop_s = can_start_s && bit_end_s;
      default: pop_s = 1'b0;
    endcase
  end

  assign bus.in_ready   = !fifo_full_s;
  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != IDLE) || !fifo_empty_s;
  assign bus.fifo_level = fifo_level_s;

  // Frame sequencer, baud counter and shift register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= 8'h00;
      div_q   <= DIV_W'(MIN_DIV);
      baud_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop_s) begin
            shift_q <= fifo_rdata_s;
            div_q   <= div_eff_s;
            baud_q  <= div_eff_s - DIV_W'(1);
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            baud_q  <= div_q - DIV_W'(1);
            cnt_q   <= cnt_q + CNT_W'(1);
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q - DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_q <= div_q - DIV_W'(1);
            cnt_q  <= cnt_q + CNT_W'(1);
            // cnt_q holds the frame bit index, so DATA_BITS marks the last data bit.
            if (cnt_q == CNT_W'(DATA_BITS)) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - DIV_W'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            if (pop_s) begin
              shift_q <= fifo_rdata_s;
              div_q   <= div_eff_s;
              baud_q  <= div_eff_s - DIV_W'(1);
              cnt_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q - DIV_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
